// File: rtl/seq_divider.sv
// Restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder, one quotient bit per clock.
// Latency: N CALC cycles plus a one-cycle DONE pulse; with DIV_OVF_CHECK_EN an overflowing request goes straight to DONE.
// Backpressure: start is sampled only while busy=0; requests made while busy are dropped and the captured operands are kept.
module seq_divider #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           ovf
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N:0]    p;
    logic [N-1:0]  a_lo;
    logic [N-1:0]  b;
    logic [N-1:0]  q;
    logic [CW-1:0] cnt;
    logic          ovf_flag;

    logic [N:0]    t_val;
    logic          qbit;
    logic [N:0]    p_next;
    logic [N-1:0]  q_next;
    logic          ovf_hit;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    always_comb begin
        t_val  = {p[N-1:0], a_lo[N-1]};
        qbit   = (t_val >= {1'b0, b});
        p_next = qbit ? (t_val - {1'b0, b}) : t_val;
        q_next = {q[N-2:0], qbit};
    end

`ifdef DIV_OVF_CHECK_EN
    assign ovf_hit = (dividend[2*N-1:N] >= divisor);
`else
    assign ovf_hit = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = ovf_hit ? DONE : CALC;
            CALC: if (cnt == '0) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            p         <= '0;
            a_lo      <= '0;
            b         <= '0;
            q         <= '0;
            cnt       <= '0;
            ovf_flag  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        p        <= {1'b0, dividend[2*N-1:N]};
                        a_lo     <= dividend[N-1:0];
                        b        <= divisor;
                        q        <= '0;
                        cnt      <= CW'(N - 1);
                        ovf_flag <= ovf_hit;
                        if (ovf_hit) begin
                            quotient  <= '1;
                            remainder <= '0;
                        end
                    end
                end
                CALC: begin
                    p    <= p_next;
                    a_lo <= {a_lo[N-2:0], 1'b0};
                    q    <= q_next;
                    cnt  <= cnt - 1'b1;
                    // Results are published only on the last step so they stay stable between runs.
                    if (cnt == '0) begin
                        quotient  <= q_next;
                        remainder <= p_next[N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign ovf  = done & ovf_flag;

endmodule
